// File: rtl/lamp_fpu_exp_pow_seq.sv
`default_nettype none
// ============================================================================
// Module      : lamp_fpu_exp_pow_seq
// Description : Issuing-side sequencer that computes y = x^n for a bfloat16
//               base x and an unsigned integer exponent n. It uses
//               right-to-left square-and-multiply. Every multiply is issued
//               to an external FPU as a single FPU_MUL transaction: opcode
//               issue, a wait for result-valid, then a padv release.
// Ports       : clk, rst (async, active-low)
//               start_i, x_i, n_i, rndMode_i     - operation request
//               fpu_opcode_o, fpu_rndMode_o,
//               fpu_op1_o, fpu_op2_o,
//               fpu_flush_o, fpu_padv_o          - FPU issue side
//               fpu_result_i, fpu_isResultValid_i - FPU result side
//               result_o, done_o, busy_o,
//               error_o, op_cnt_o                - status / result
// Revision    : 1.0 - initial release
// ============================================================================
module lamp_fpu_exp_pow_seq #(
    parameter int N_W         = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int DW          = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [DW-1:0]   x_i,
    input  logic [N_W-1:0]  n_i,
    input  logic [2:0]      rndMode_i,
    output logic [3:0]      fpu_opcode_o,
    output logic [2:0]      fpu_rndMode_o,
    output logic [DW-1:0]   fpu_op1_o,
    output logic [DW-1:0]   fpu_op2_o,
    output logic            fpu_flush_o,
    output logic            fpu_padv_o,
    input  logic [DW-1:0]   fpu_result_i,
    input  logic            fpu_isResultValid_i,
    output logic [DW-1:0]   result_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            error_o,
    output logic [N_W:0]    op_cnt_o
);

    // FPU opcode / rounding-mode encodings of the LAMP FPU top.
    localparam logic [3:0] FPU_IDLE            = 4'd0;
    localparam logic [3:0] FPU_MUL             = 4'd5;
    localparam logic [2:0] FPU_RNDMODE_NEAREST = 3'd0;

    localparam logic [DW-1:0] C_ONE  = DW'(16'h3F80);
    localparam logic [DW-1:0] C_QNAN = DW'(16'h7FC0);

    localparam int            TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] C_TMO_ONE  = TMO_W'(1);
    localparam logic [N_W:0]     C_CNT_ONE  = (N_W+1)'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECIDE = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic PH_MUL = 1'b0;
    localparam logic PH_SQR = 1'b1;

    logic [2:0]       state_q,  state_d;
    logic [DW-1:0]    acc_q,    acc_d;
    logic [DW-1:0]    base_q,   base_d;
    logic [N_W-1:0]   e_q,      e_d;
    logic             phase_q,  phase_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic [DW-1:0]    op1_q,    op1_d;
    logic [DW-1:0]    op2_q,    op2_d;
    logic [DW-1:0]    result_q, result_d;
    logic             error_q,  error_d;
    logic [N_W:0]     cnt_q,    cnt_d;
    logic [2:0]       rnd_q,    rnd_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        e_d      = e_q;
        phase_d  = phase_q;
        tmo_d    = tmo_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        rnd_d    = rnd_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = C_ONE;
                    base_d  = x_i;
                    e_d     = n_i;
                    phase_d = PH_MUL;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    rnd_d   = rndMode_i;
                    state_d = S_DECIDE;
                end
            end

            S_DECIDE: begin
                if (phase_q == PH_MUL) begin
                    if (e_q == '0) begin
                        result_d = acc_q;
                        state_d  = S_DONE;
                    end else if (e_q[0]) begin
                        op1_d   = acc_q;
                        op2_d   = base_q;
                        state_d = S_ISSUE;
                    end else begin
                        // Even remaining exponent: no multiply, go square.
                        phase_d = PH_SQR;
                    end
                end else begin
                    // The base is only squared while higher exponent bits
                    // remain; the last square would be wasted work.
                    e_d = e_q >> 1;
                    if ((e_q >> 1) == '0) begin
                        result_d = acc_q;
                        state_d  = S_DONE;
                    end else begin
                        op1_d   = base_q;
                        op2_d   = base_q;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                cnt_d   = cnt_q + C_CNT_ONE;
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (fpu_isResultValid_i) begin
                    if (phase_q == PH_MUL) begin
                        acc_d = fpu_result_i;
                    end else begin
                        base_d = fpu_result_i;
                    end
                    state_d = S_ACK;
                end else if (tmo_q == C_TMO_LAST) begin
                    error_d  = 1'b1;
                    result_d = C_QNAN;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + C_TMO_ONE;
                end
            end

            S_ACK: begin
                phase_d = ~phase_q;
                state_d = S_DECIDE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            e_q      <= '0;
            phase_q  <= PH_MUL;
            tmo_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            rnd_q    <= FPU_RNDMODE_NEAREST;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            e_q      <= e_d;
            phase_q  <= phase_d;
            tmo_q    <= tmo_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            rnd_q    <= rnd_d;
        end
    end

    assign fpu_opcode_o  = (state_q == S_ISSUE) ? FPU_MUL : FPU_IDLE;
    assign fpu_rndMode_o = rnd_q;
    assign fpu_op1_o     = op1_q;
    assign fpu_op2_o     = op2_q;
    assign fpu_flush_o   = 1'b0;
    assign fpu_padv_o    = (state_q == S_ACK);
    assign result_o      = result_q;
    assign done_o        = (state_q == S_DONE);
    assign busy_o        = (state_q != S_IDLE);
    assign error_o       = error_q;
    assign op_cnt_o      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lamp_fpu_exp_pow_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lamp_fpu_exp_pow_seq
// Description : Self-checking bench for lamp_fpu_exp_pow_seq. Contains a
//               bfloat16 multiplier FPU model with random latency, a
//               protocol monitor and a square-and-multiply reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lamp_fpu_exp_pow_seq;

    localparam logic [3:0] MUL_OP = 4'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] x_i = '0;
    logic [7:0]  n_i = '0;
    logic [2:0]  rnd_i = '0;

    logic [3:0]  fpu_opcode_o;
    logic [2:0]  fpu_rndMode_o;
    logic [15:0] fpu_op1_o, fpu_op2_o;
    logic        fpu_flush_o, fpu_padv_o;
    logic [15:0] fpu_res = '0;
    logic        fpu_valid = 1'b0;
    logic [15:0] result_o;
    logic        done_o, busy_o, error_o;
    logic [8:0]  op_cnt_o;

    lamp_fpu_exp_pow_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_i             (start_i),
        .x_i                 (x_i),
        .n_i                 (n_i),
        .rndMode_i           (rnd_i),
        .fpu_opcode_o        (fpu_opcode_o),
        .fpu_rndMode_o       (fpu_rndMode_o),
        .fpu_op1_o           (fpu_op1_o),
        .fpu_op2_o           (fpu_op2_o),
        .fpu_flush_o         (fpu_flush_o),
        .fpu_padv_o          (fpu_padv_o),
        .fpu_result_i        (fpu_res),
        .fpu_isResultValid_i (fpu_valid),
        .result_o            (result_o),
        .done_o              (done_o),
        .busy_o              (busy_o),
        .error_o             (error_o),
        .op_cnt_o            (op_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // bfloat16 multiply, round-to-nearest-even, normal operands/results only.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] pm;
        int          ex;
        logic [6:0]  m;
        logic        g, st;
        logic [15:0] r;
        pm = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        ex = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (pm[15]) begin
            ex = ex + 1; m = pm[14:8]; g = pm[7]; st = |pm[6:0];
        end else begin
            m = pm[13:7]; g = pm[6]; st = |pm[5:0];
        end
        r = {a[15] ^ b[15], ex[7:0], m};
        if (g && (st || m[0])) r[14:0] = r[14:0] + 15'd1;
        return r;
    endfunction

    // ---------------- FPU model ----------------
    bit          fpu_dead = 1'b0;
    int          lat_max  = 1;
    logic        pend = 1'b0;
    logic [15:0] pend_res = '0;
    int          lat_cnt = 0;
    logic [31:0] seen_ops[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpu_valid <= 1'b0;
            pend      <= 1'b0;
            lat_cnt   <= 0;
        end else begin
            if (fpu_valid && fpu_padv_o) fpu_valid <= 1'b0;
            if (fpu_opcode_o == MUL_OP) begin
                seen_ops.push_back({fpu_op1_o, fpu_op2_o});
                pend_res <= fmul(fpu_op1_o, fpu_op2_o);
                lat_cnt  <= int'($urandom_range(1, lat_max));
                pend     <= 1'b1;
            end else if (pend) begin
                if (lat_cnt <= 1) begin
                    fpu_valid <= !fpu_dead;
                    fpu_res   <= pend_res;
                    pend      <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int   viol = 0, padv_total = 0, mul_total = 0;
    logic prev_padv = 1'b0, prev_mul = 1'b0;

    always @(posedge clk) begin
        viol <= viol + int'(fpu_padv_o && !fpu_valid)
                     + int'((fpu_opcode_o == MUL_OP) && (prev_padv || prev_mul));
        if (fpu_padv_o) padv_total <= padv_total + 1;
        if (fpu_opcode_o == MUL_OP) mul_total <= mul_total + 1;
        prev_padv <= fpu_padv_o;
        prev_mul  <= (fpu_opcode_o == MUL_OP);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int         op_base_idx = 0;
    logic [2:0] exp_rnd = '0;

    task automatic run_op(input logic [15:0] x, input logic [7:0] n, input bit spam,
                          output int cyc);
        @(negedge clk);
        op_base_idx = seen_ops.size();
        x_i = x; n_i = n; rnd_i = 3'($urandom); exp_rnd = rnd_i; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        while (done_o !== 1'b1 && cyc < 3000) begin
            if (spam) begin
                start_i = 1'($urandom); x_i = 16'($urandom);
                n_i = 8'($urandom); rnd_i = 3'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [15:0] x, input logic [7:0] n);
        logic [15:0] acc, b;
        logic [7:0]  k;
        logic [31:0] exq[$];
        bit          seq_ok;
        int          nexp;
        acc = 16'h3F80; b = x; k = n;
        while (k != 0) begin
            if (k[0]) begin exq.push_back({acc, b}); acc = fmul(acc, b); end
            k = k >> 1;
            if (k != 0) begin exq.push_back({b, b}); b = fmul(b, b); end
        end
        nexp = (n == 0) ? 0 : $countones(n) + $clog2(int'(n) + 1) - 1;
        seq_ok = ((seen_ops.size() - op_base_idx) == exq.size());
        if (seq_ok)
            foreach (exq[i]) if (seen_ops[op_base_idx + i] !== exq[i]) seq_ok = 1'b0;
        chk({tag, " done"},   64'(done_o),        64'd1);
        chk({tag, " result"}, 64'(result_o),      64'(acc));
        chk({tag, " op_cnt"}, 64'(op_cnt_o),      64'(nexp));
        chk({tag, " error"},  64'(error_o),       64'd0);
        chk({tag, " rnd"},    64'(fpu_rndMode_o), 64'(exp_rnd));
        chk({tag, " op_seq"}, 64'(seq_ok),        64'd1);
        @(negedge clk);
        chk({tag, " done/busy drop"}, 64'({done_o, busy_o}), 64'd0);
        chk({tag, " result hold"},    64'(result_o),         64'(acc));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " data outs"}, 64'({fpu_op1_o, fpu_op2_o, result_o}), 64'd0);
        chk({tag, " ctrl outs"}, 64'({fpu_opcode_o, fpu_rndMode_o, fpu_flush_o, fpu_padv_o,
                                      done_o, busy_o, error_o, op_cnt_o}), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          cyc, v0, p0, m0, w;
        logic [15:0] rx;
        logic [7:0]  rn;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;

        // 2.0^5
        lat_max = 1;
        run_op(16'h4000, 8'd5, 1'b0, cyc);
        chk("pow2_5 value", 64'(result_o), 64'h4200);
        check_op("pow2_5", 16'h4000, 8'd5);

        // (-1.5)^2
        lat_max = 3;
        run_op(16'hBFC0, 8'd2, 1'b0, cyc);
        chk("m1p5_sq value", 64'(result_o), 64'h4010);
        check_op("m1p5_sq", 16'hBFC0, 8'd2);

        // n = 0
        run_op(16'h1234, 8'd0, 1'b0, cyc);
        chk("n0 latency", 64'(cyc), 64'd2);
        check_op("n0", 16'h1234, 8'd0);

        // FPU never answers
        fpu_dead = 1'b1;
        p0 = padv_total;
        run_op(16'h4000, 8'd1, 1'b0, cyc);
        chk("tmo latency", 64'(cyc), 64'd67);
        chk("tmo error",   64'(error_o),  64'd1);
        chk("tmo result",  64'(result_o), 64'h7FC0);
        chk("tmo op_cnt",  64'(op_cnt_o), 64'd1);
        chk("tmo no padv", 64'(padv_total - p0), 64'd0);
        fpu_dead = 1'b0;

        // error cleared by next start
        lat_max = 2;
        run_op(16'h3FC0, 8'd3, 1'b0, cyc);
        check_op("after_tmo", 16'h3FC0, 8'd3);

        // protocol run: n=255, random latency, start spam while busy
        lat_max = 5;
        v0 = viol; m0 = mul_total;
        run_op(16'hBF81, 8'd255, 1'b1, cyc);
        chk("proto mul count", 64'(mul_total - m0), 64'd15);
        check_op("proto", 16'hBF81, 8'd255);
        chk("proto violations", 64'(viol - v0), 64'd0);

        // random operands
        for (int i = 0; i < 8; i++) begin
            rx = {1'($urandom), 8'($urandom_range(126, 128)), 7'($urandom)};
            rn = 8'($urandom_range(0, 63));
            lat_max = int'($urandom_range(1, 5));
            run_op(rx, rn, 1'b0, cyc);
            check_op($sformatf("rand%0d", i), rx, rn);
        end

        // asynchronous reset during WAIT
        lat_max = 5;
        @(negedge clk);
        x_i = 16'h3F81; n_i = 8'd255; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        w = 0;
        while (fpu_opcode_o !== MUL_OP && w < 50) begin @(negedge clk); w++; end
        chk("rst issue seen", 64'(fpu_opcode_o == MUL_OP), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        run_op(16'h4040, 8'd6, 1'b0, cyc);
        check_op("post_reset", 16'h4040, 8'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lamp_fpu_exp_pow_seq.md
Name: lamp_fpu_exp_pow_seq

Overview:
- Issuing-side sequencer for the bfloat16 FPU multiply interface (opcode/operand issue, result-valid wait, padv release).
- Computes y = x^n for a bfloat16 x and an unsigned integer n using right-to-left square-and-multiply.
- Each multiply is issued as one FPU_MUL transaction to an external FPU top, so this block sits between the exponential datapath control and the FPU.

Parameters:
- N_W, 8, width of the integer exponent n.
- TIMEOUT_CYC, 64, maximum cycles spent in WAIT before the operation is aborted with an error.
- DW, 16, float width; equal to LAMP_FLOAT_MUL_DW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin operation; sampled in IDLE only.
- x_i  in  DW  bfloat16 base; latched on accepted start.
- n_i  in  N_W  unsigned exponent; latched on accepted start.
- rndMode_i  in  rndModeFPU_t  rounding mode; latched on start and driven to the FPU.
- fpu_opcode_o  out  opcodeFPU_t  FPU_MUL in ISSUE, FPU_IDLE otherwise.
- fpu_rndMode_o  out  rndModeFPU_t  latched rounding mode.
- fpu_op1_o, fpu_op2_o  out  DW  operands; meaningful only in ISSUE.
- fpu_flush_o  out  1  constant 0.
- fpu_padv_o  out  1  one-cycle release pulse in ACK.
- fpu_result_i  in  DW  FPU result.
- fpu_isResultValid_i  in  1  FPU result valid (level, held until padv).
- result_o  out  DW  x^n; stable from done_o until next accepted start.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in every state except IDLE.
- error_o  out  1  set with done_o on timeout; cleared on next start.
- op_cnt_o  out  N_W+1  number of FPU_MUL issued in the current or last operation.

Behaviour:
- Reset (rst=0, async): state IDLE.
  - All outputs 0, except fpu_opcode_o=FPU_IDLE and fpu_rndMode_o=FPU_RNDMODE_NEAREST.
  - Registers: acc=0, base=0, e=0, phase=MUL.
  - Reset mid-operation abandons the operation; the FPU side must be reset with it.
- Internal registers: acc (DW), base (DW), e (N_W), phase {MUL, SQR}, timeout counter ($clog2(TIMEOUT_CYC+1) bits).
- IDLE: on start_i=1:
  - Set acc=0x3F80 (1.0), base=x_i, e=n_i, phase=MUL.
  - Clear op_cnt_o and error_o; latch rndMode_i.
  - Go to DECIDE. start_i outside IDLE is ignored.
- DECIDE (1 cycle):
  - phase=MUL: if e==0, go to DONE. Else if e[0]=1, go to ISSUE with op1=acc, op2=base. Else set phase=SQR and stay in DECIDE.
  - phase=SQR: e<=e>>1. If (e>>1)==0, go to DONE. Else go to ISSUE with op1=base, op2=base.
- ISSUE (exactly 1 cycle):
  - fpu_opcode_o=FPU_MUL; operands valid in the same cycle. The FPU samples opcode and operands on this edge.
  - op_cnt_o increments; clear the timeout counter; go to WAIT.
- WAIT:
  - fpu_opcode_o=FPU_IDLE; operand outputs hold their last values.
  - On fpu_isResultValid_i=1: capture fpu_result_i into acc (phase=MUL) or base (phase=SQR); go to ACK.
  - If the counter reaches TIMEOUT_CYC first: set error_o=1, result_o=0x7FC0 (qNaN), go to DONE. No padv is issued.
- ACK (1 cycle):
  - fpu_padv_o=1.
  - If phase=MUL, set phase=SQR. If phase=SQR, set phase=MUL.
  - Go to DECIDE. No new ISSUE is possible in the ACK cycle, since the FPU ignores opcodes while in DONE.
- DONE (1 cycle):
  - done_o=1; result_o=acc unless a timeout occurred; go to IDLE.
  - busy_o drops the cycle after done_o.
- Operation count = popcount(n) + (bit-length(n) − 1). n=0 issues zero ops.
- Minimum latency per multiply: DECIDE + ISSUE + WAIT + ACK = FPU latency + 3 cycles.
- Simultaneous fpu_isResultValid_i=1 and timeout on the same cycle: the result wins.
- Special-value propagation (NaN, Inf, zero, overflow) is entirely the FPU's; there is no special-casing here.

Test Plan:
- x=0x4000 (2.0), n=5 -> 4 MULs in the order acc·base, base², base², acc·base; result_o=0x4200; op_cnt_o=4; error_o=0.
- x=0xBFC0 (−1.5), n=2 -> 2 MULs (base², acc·base); result_o=0x4010 (2.25).
- n=0, any x -> no FPU_MUL issued; done_o pulses 2 cycles after start; result_o=0x3F80; op_cnt_o=0.
- FPU model never asserts valid, with n=1 -> done_o after TIMEOUT_CYC WAIT cycles; error_o=1; result_o=0x7FC0; fpu_padv_o never pulses.
- Protocol checks, n=255 with random FPU latency 1–5 -> fpu_opcode_o=FPU_MUL for exactly one cycle per op; padv only while valid is high; no issue in the cycle after padv; op_cnt_o=15; start_i pulses while busy are ignored.
- Assert rst low during WAIT -> all outputs return to their reset values immediately; a new start after release gives a correct result.
